sdram_arbiter: RTL

//  Two-client round-robin arbiter in front of the sdram_controller host port.

---
 rtl/sdram_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//
// Two-client round-robin arbiter in front of the sdram_controller host port.
// Each client issues single-word reads or writes with a req/done handshake.
// The arbiter serialises them onto the controller's rd_enable/wr_enable/busy
// interface, holds the enable until busy is seen, and returns read data to
// the client that issued the read.
//
// Ports
//   clk, rst        system clock (rising edge) and async active-high reset
//   cN_req          client N request, held high until cN_done
//   cN_we           client N direction: 1 = write, 0 = read
//   cN_addr         client N word address
//   cN_wdata        client N write data
//   cN_done         one-cycle completion pulse for client N
//   cN_rdata        client N read data, valid with cN_done
//   sd_addr         controller address (wr_addr)
//   sd_wdata        controller write data
//   sd_rdata        controller read data
//   sd_busy         controller busy
//   sd_wr_enable    controller write enable
//   sd_rd_enable    controller read enable
//   err             sticky issue-timeout flag, cleared only by rst
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int ADDR_WIDTH    = 24,
    parameter int DATA_WIDTH    = 16,
    parameter int ISSUE_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c0_req,
    input  logic                  c0_we,
    input  logic [ADDR_WIDTH-1:0] c0_addr,
    input  logic [DATA_WIDTH-1:0] c0_wdata,
    output logic                  c0_done,
    output logic [DATA_WIDTH-1:0] c0_rdata,
    input  logic                  c1_req,
    input  logic                  c1_we,
    input  logic [ADDR_WIDTH-1:0] c1_addr,
    input  logic [DATA_WIDTH-1:0] c1_wdata,
    output logic                  c1_done,
    output logic [DATA_WIDTH-1:0] c1_rdata,
    output logic [ADDR_WIDTH-1:0] sd_addr,
    output logic [DATA_WIDTH-1:0] sd_wdata,
    input  logic [DATA_WIDTH-1:0] sd_rdata,
    input  logic                  sd_busy,
    output logic                  sd_wr_enable,
    output logic                  sd_rd_enable,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_COUNT = 8'(ISSUE_TIMEOUT);

    state_t                  state_reg,      state_next;
    logic                    last_grant_reg, last_grant_next;
    logic                    id_reg,         id_next;
    logic                    we_reg,         we_next;
    logic [7:0]              count_reg,      count_next;
    logic [ADDR_WIDTH-1:0]   addr_reg,       addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg,      wdata_next;
    logic                    wr_en_reg,      wr_en_next;
    logic                    rd_en_reg,      rd_en_next;
    logic                    done0_reg,      done0_next;
    logic                    done1_reg,      done1_next;
    logic [DATA_WIDTH-1:0]   rdata0_reg,     rdata0_next;
    logic [DATA_WIDTH-1:0]   rdata1_reg,     rdata1_next;
    logic                    err_reg,        err_next;

    // Combinational helpers
    logic                    grant;
    logic                    grant_we;
    logic                    complete;
    logic [DATA_WIDTH-1:0]   complete_data;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        id_next         = id_reg;
        we_next         = we_reg;
        count_next      = count_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        wr_en_next      = wr_en_reg;
        rd_en_next      = rd_en_reg;
        done0_next      = 1'b0;
        done1_next      = 1'b0;
        rdata0_next     = rdata0_reg;
        rdata1_next     = rdata1_reg;
        err_next        = err_reg;
        grant           = 1'b0;
        grant_we        = 1'b0;
        complete        = 1'b0;
        complete_data   = '0;

        case (state_reg)
            IDLE: begin
                // A busy controller (refresh/init) blocks any new grant.
                if (!sd_busy && (c0_req || c1_req)) begin
                    // On a tie the client that did not win last time goes.
                    if (c0_req && c1_req) begin
                        grant = ~last_grant_reg;
                    end else begin
                        grant = c1_req;
                    end
                    grant_we   = grant ? c1_we : c0_we;
                    id_next    = grant;
                    we_next    = grant_we;
                    addr_next  = grant ? c1_addr  : c0_addr;
                    wdata_next = grant ? c1_wdata : c0_wdata;
                    wr_en_next = grant_we;
                    rd_en_next = ~grant_we;
                    count_next = 8'd1;
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                if (sd_busy) begin
                    wr_en_next = 1'b0;
                    rd_en_next = 1'b0;
                    state_next = WAIT_DONE;
                end else if (count_reg == TIMEOUT_COUNT) begin
                    // Controller never acknowledged: give up and report.
                    wr_en_next = 1'b0;
                    rd_en_next = 1'b0;
                    err_next   = 1'b1;
                    complete   = 1'b1;
                end else begin
                    count_next = count_reg + 8'd1;
                end
            end

            WAIT_DONE: begin
                if (!sd_busy) begin
                    complete      = 1'b1;
                    complete_data = we_reg ? '0 : sd_rdata;
                end
            end

            RESP: begin
                last_grant_next = id_reg;
                state_next      = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Only the granted client's done/rdata change; the other holds.
        if (complete) begin
            state_next = RESP;
            if (id_reg) begin
                done1_next  = 1'b1;
                rdata1_next = complete_data;
            end else begin
                done0_next  = 1'b1;
                rdata0_next = complete_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            we_reg         <= 1'b0;
            count_reg      <= 8'd0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wr_en_reg      <= 1'b0;
            rd_en_reg      <= 1'b0;
            done0_reg      <= 1'b0;
            done1_reg      <= 1'b0;
            rdata0_reg     <= '0;
            rdata1_reg     <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            id_reg         <= id_next;
            we_reg         <= we_next;
            count_reg      <= count_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            wr_en_reg      <= wr_en_next;
            rd_en_reg      <= rd_en_next;
            done0_reg      <= done0_next;
            done1_reg      <= done1_next;
            rdata0_reg     <= rdata0_next;
            rdata1_reg     <= rdata1_next;
            err_reg        <= err_next;
        end
    end

    assign sd_addr      = addr_reg;
    assign sd_wdata     = wdata_reg;
    assign sd_wr_enable = wr_en_reg;
    assign sd_rd_enable = rd_en_reg;
    assign c0_done      = done0_reg;
    assign c1_done      = done1_reg;
    assign c0_rdata     = rdata0_reg;
    assign c1_rdata     = rdata1_reg;
    assign err          = err_reg;

endmodule
